// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART block: the
//                auto-baud FSM state encoding, the baud-generator field
//                widths and the sync-character geometry.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   // Baud generator field widths
   localparam int BAUD_W          = 13;
   localparam int FRAC_W          = 3;

   // The generator runs at 16x the bit rate
   localparam int OVERSAMPLE_LOG2 = 4;

   // The 0x55 sync character spans 8 bit-times between its first and last
   // falling edge, so total count / (8 * 16) gives the generator divisor
   localparam int SYNC_BITS       = 8;
   localparam int DIV_SHIFT       = OVERSAMPLE_LOG2 + $clog2(SYNC_BITS);

   // Auto-baud controller states
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_START = 3'd1,
      MEASURE    = 3'd2,
      CALC       = 3'd3,
      LOCKED     = 3'd4,
      ERROR      = 3'd5
   } ab_state_e;

   // States in which a measurement is armed or running
   function automatic logic ab_is_busy(input ab_state_e s);
      return (s == WAIT_START) || (s == MEASURE);
   endfunction

   // States in which the receiver must ignore the line
   function automatic logic ab_holds_rx(input ab_state_e s);
      return (s == WAIT_START) || (s == MEASURE) || (s == CALC);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_edge_sync.sv
// ============================================================================
//  Module      : uart_rx_edge_sync
//  Description : Two-flop synchroniser for the asynchronous RX line plus a
//                falling-edge detector. All flops reset to the idle (mark)
//                level so a reset never manufactures an edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_edge_sync (
   input  logic clk,
   input  logic aresetn,
   input  logic rx_i,
   output logic fall_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Resynchronise the line and keep one sample of history for edge detection
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // High for exactly one cycle when the synchronised line goes 1 -> 0
   assign fall_o = prev_q & ~sync2_q;

endmodule

`default_nettype wire

// File: rtl/uart_autobaud_ctrl.sv
// ============================================================================
//  Module      : uart_autobaud_ctrl
//  Description : Auto-baud configuration controller for the UART 16x baud
//                generator. Times the falling edges of a received 0x55,
//                converts the 8-bit-time total into a baud value and
//                fractional adjust, then holds them and flags lock. A
//                software override passes register values straight through.
//  Options     : UART_AUTOBAUD_FRACTION_EN
//                  defined   - fraction = C[6:4], baud = C[19:7] - 1
//                  undefined - fraction = 0, baud = round(C / 128) - 1
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_autobaud_ctrl
   import uart_pkg::*;
#(
   parameter int              CNT_W       = 20,
   parameter logic [CNT_W-1:0] TIMEOUT_CNT = 20'hFFFFF,
   parameter int              TOL_SHIFT   = 3
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              enable,
   input  logic              restart,
   input  logic              rx_in,
   input  logic              sw_override,
   input  logic [BAUD_W-1:0] sw_baud_val,
   input  logic [FRAC_W-1:0] sw_fraction,
   output logic [BAUD_W-1:0] baud_val,
   output logic [FRAC_W-1:0] baud_val_fraction,
   output logic              baud_locked,
   output logic              detect_err,
   output logic              rx_hold,
   output logic              busy
);

   // Quotient carries one extra bit so the rounded form cannot wrap
   localparam int Q_W = CNT_W - DIV_SHIFT + 1;

   // ------------------------------------------------------------------------
   // Line conditioning
   // ------------------------------------------------------------------------
   logic w_fall;

   uart_rx_edge_sync u_edge_sync (
      .clk     (clk),
      .aresetn (aresetn),
      .rx_i    (rx_in),
      .fall_o  (w_fall)
   );

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   ab_state_e         state_q,    state_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;       // cycles since the start edge
   logic [CNT_W-1:0]  last_q,     last_d;      // count at the previous edge
   logic [CNT_W-1:0]  ref_q,      ref_d;       // first interval
   logic [CNT_W-1:0]  total_q,    total_d;     // count at the final edge
   logic [1:0]        edge_cnt_q, edge_cnt_d;  // intervals already latched
   logic [BAUD_W-1:0] baud_q,     baud_d;
   logic [FRAC_W-1:0] frac_q,     frac_d;
   logic              locked_q,   locked_d;
   logic              err_q,      err_d;
   logic              hold_q;
   logic              busy_q;

   // ------------------------------------------------------------------------
   // Interval arithmetic
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] w_interval;
   logic [CNT_W-1:0] w_diff;
   logic             w_in_tol;
   logic             w_timeout;

   // The count an edge sees includes the cycle it arrives in, so the
   // distance between two edges N cycles apart reads exactly N
   assign w_cnt_inc  = cnt_q + CNT_W'(1);
   assign w_interval = w_cnt_inc - last_q;
   assign w_diff     = (w_interval >= ref_q) ? (w_interval - ref_q)
                                             : (ref_q - w_interval);
   assign w_in_tol   = (w_diff <= (ref_q >> TOL_SHIFT));
   assign w_timeout  = (w_cnt_inc >= TIMEOUT_CNT);

   // ------------------------------------------------------------------------
   // Divisor from total count: 8 bit-times x 16 oversample = /128
   // ------------------------------------------------------------------------
   logic [Q_W-1:0]    w_quot;
   logic [Q_W-1:0]    w_quot_m1;
   logic [FRAC_W-1:0] w_frac;

`ifdef UART_AUTOBAUD_FRACTION_EN
   // Truncated quotient; the next three bits are the eighths remainder
   assign w_quot = {1'b0, total_q[CNT_W-1:DIV_SHIFT]};
   assign w_frac = total_q[DIV_SHIFT-1 -: FRAC_W];
`else
   logic [CNT_W:0] w_rounded;

   // Add half a divisor before truncating to round to nearest
   assign w_rounded = {1'b0, total_q} + (CNT_W+1)'(1 << (DIV_SHIFT - 1));
   assign w_quot    = w_rounded[CNT_W:DIV_SHIFT];
   assign w_frac    = '0;
`endif

   assign w_quot_m1 = w_quot - Q_W'(1);

   // ------------------------------------------------------------------------
   // Next-state logic: override > disable > restart > normal sequencing
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      ref_d      = ref_q;
      total_d    = total_q;
      edge_cnt_d = edge_cnt_q;
      baud_d     = baud_q;
      frac_d     = frac_q;
      locked_d   = locked_q;
      err_d      = err_q;

      if (sw_override) begin
         // Register values pass through and the measurement engine parks
         state_d  = IDLE;
         baud_d   = sw_baud_val;
         frac_d   = sw_fraction;
         locked_d = 1'b1;
         err_d    = 1'b0;
      end else if (!enable) begin
         // Drop status but keep the last divisor driving the generator
         state_d  = IDLE;
         locked_d = 1'b0;
         err_d    = 1'b0;
      end else if (restart) begin
         state_d  = WAIT_START;
         locked_d = 1'b0;
         err_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = WAIT_START;
               locked_d = 1'b0;
            end

            WAIT_START: begin
               if (w_fall) begin
                  cnt_d      = '0;
                  last_d     = '0;
                  edge_cnt_d = '0;
                  state_d    = MEASURE;
               end
            end

            MEASURE: begin
               cnt_d = w_cnt_inc;
               if (w_fall) begin
                  last_d     = w_cnt_inc;
                  edge_cnt_d = edge_cnt_q + 2'd1;
                  if (edge_cnt_q == 2'd0) begin
                     ref_d = w_interval;
                  end else if (!w_in_tol) begin
                     state_d = ERROR;
                     err_d   = 1'b1;
                  end else if (edge_cnt_q == 2'd3) begin
                     total_d = w_cnt_inc;
                     state_d = CALC;
                  end
               end else if (w_timeout) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
               end
            end

            CALC: begin
               // A zero divisor cannot be programmed; reject instead
               if (w_quot == '0) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
               end else begin
                  baud_d   = w_quot_m1[BAUD_W-1:0];
                  frac_d   = w_frac;
                  locked_d = 1'b1;
                  state_d  = LOCKED;
               end
            end

            LOCKED: begin
               state_d = LOCKED;
            end

            ERROR: begin
               state_d = ERROR;
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, measurement registers and all outputs update together
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_q     <= '0;
         ref_q      <= '0;
         total_q    <= '0;
         edge_cnt_q <= '0;
         baud_q     <= '0;
         frac_q     <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         hold_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         ref_q      <= ref_d;
         total_q    <= total_d;
         edge_cnt_q <= edge_cnt_d;
         baud_q     <= baud_d;
         frac_q     <= frac_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         hold_q     <= ab_holds_rx(state_d);
         busy_q     <= ab_is_busy(state_d);
      end
   end

   assign baud_val          = baud_q;
   assign baud_val_fraction = frac_q;
   assign baud_locked       = locked_q;
   assign detect_err        = err_q;
   assign rx_hold           = hold_q;
   assign busy              = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_autobaud_ctrl.sv
// ============================================================================
//  Module      : tb_uart_autobaud_ctrl
//  Description : Self-checking bench for uart_autobaud_ctrl. Frames are
//                driven in whole clock cycles; expected lock results come
//                from a small divisor model and sit in a scoreboard queue
//                until the DUT reports lock or error.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_autobaud_ctrl;

   logic        clk = 1'b0;
   logic        aresetn;
   logic        enable;
   logic        restart;
   logic        rx;
   logic        rx_to;
   logic        sw_override;
   logic [12:0] sw_baud_val;
   logic [2:0]  sw_fraction;

   logic [12:0] baud_val;
   logic [2:0]  baud_val_fraction;
   logic        baud_locked;
   logic        detect_err;
   logic        rx_hold;
   logic        busy;

   logic [12:0] baud_to;
   logic [2:0]  frac_to;
   logic        locked_to;
   logic        err_to;
   logic        hold_to;
   logic        busy_to;

   typedef struct packed {
      logic        locked;
      logic        err;
      logic [12:0] baud;
      logic [2:0]  frac;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [12:0] last_baud = '0;
   logic [2:0]  last_frac = '0;

   always #10 clk = ~clk;

   uart_autobaud_ctrl dut (
      .clk               (clk),
      .aresetn           (aresetn),
      .enable            (enable),
      .restart           (restart),
      .rx_in             (rx),
      .sw_override       (sw_override),
      .sw_baud_val       (sw_baud_val),
      .sw_fraction       (sw_fraction),
      .baud_val          (baud_val),
      .baud_val_fraction (baud_val_fraction),
      .baud_locked       (baud_locked),
      .detect_err        (detect_err),
      .rx_hold           (rx_hold),
      .busy              (busy)
   );

   uart_autobaud_ctrl #(.TIMEOUT_CNT(20'h01000)) dut_to (
      .clk               (clk),
      .aresetn           (aresetn),
      .enable            (enable),
      .restart           (restart),
      .rx_in             (rx_to),
      .sw_override       (1'b0),
      .sw_baud_val       (13'd0),
      .sw_fraction       (3'd0),
      .baud_val          (baud_to),
      .baud_val_fraction (frac_to),
      .baud_locked       (locked_to),
      .detect_err        (err_to),
      .rx_hold           (hold_to),
      .busy              (busy_to)
   );

   // Independent divisor model from the total 8-bit-time count
   function automatic exp_t model_lock(input int c);
      exp_t        e;
      logic [20:0] cc;
      logic [20:0] q;
      cc = 21'(c);
`ifdef UART_AUTOBAUD_FRACTION_EN
      q      = cc >> 7;
      e.frac = cc[6:4];
`else
      q      = (cc + 21'd64) >> 7;
      e.frac = 3'd0;
`endif
      e.baud   = 13'(q - 21'd1);
      e.locked = 1'b1;
      e.err    = 1'b0;
      return e;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // 8N1 frame; bits lo..hi (0 = start, 1..8 = data, 9 = stop) get extra cycles
   task automatic send_frame(input logic [7:0] b, input int bitc, input int lo,
                             input int hi, input int extra, input bit to_dut2);
      for (int i = 0; i < 10; i++) begin
         logic lvl;
         lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
         if (to_dut2) rx_to = lvl;
         else         rx    = lvl;
         tick(bitc + (((i >= lo) && (i <= hi)) ? extra : 0));
      end
   endtask

   // Wait for lock or error on the chosen instance, bounded by budget
   task automatic wait_out(input int budget, input bit on_dut2, output int waited);
      waited = 0;
      while (!(on_dut2 ? (locked_to || err_to) : (baud_locked || detect_err))
             && (waited < budget)) begin
         tick(1);
         waited++;
      end
   endtask

   task automatic test_reset;
      aresetn = 1'b0; enable = 1'b0; restart = 1'b0; rx = 1'b1; rx_to = 1'b1;
      sw_override = 1'b0; sw_baud_val = '0; sw_fraction = '0;
      tick(3);
      n_checks++;
      if ({baud_val, baud_val_fraction, baud_locked, detect_err, rx_hold, busy} !== 19'd0)
         $display("FAIL reset_outputs: got %h want 0",
                  {baud_val, baud_val_fraction, baud_locked, detect_err, rx_hold, busy});
      else n_pass++;
      n_checks++;
      if ({baud_to, frac_to, locked_to, err_to, hold_to, busy_to} !== 19'd0)
         $display("FAIL reset_outputs_to: got %h want 0",
                  {baud_to, frac_to, locked_to, err_to, hold_to, busy_to});
      else n_pass++;
      aresetn = 1'b1;
      tick(2);
      n_checks++;
      if ({busy, rx_hold} !== 2'b00)
         $display("FAIL idle_disabled: busy/hold got %b want 00", {busy, rx_hold});
      else n_pass++;
   endtask

   task automatic test_lock_115200;
      exp_t e;
      int   w;
      enable = 1'b1;
      tick(3);
      n_checks++;
      if ({busy, rx_hold} !== 2'b11)
         $display("FAIL wait_start_flags: busy/hold got %b want 11", {busy, rx_hold});
      else n_pass++;
      sb.push_back(model_lock(8 * 434));
      send_frame(8'h55, 434, 0, -1, 0, 1'b0);
      wait_out(100, 1'b0, w);
      e = sb.pop_front();
      n_checks++;
      if (w >= 100)
         $display("FAIL lock115200: timed out waiting for lock");
      else if ({baud_locked, detect_err, baud_val, baud_val_fraction} !== e)
         $display("FAIL lock115200: got L%b E%b %0d/%0d want L%b E%b %0d/%0d",
                  baud_locked, detect_err, baud_val, baud_val_fraction,
                  e.locked, e.err, e.baud, e.frac);
      else n_pass++;
      last_baud = e.baud; last_frac = e.frac;
   endtask

   task automatic test_lock_9600;
      exp_t e;
      int   w;
      restart = 1'b1; tick(1); restart = 1'b0;
      n_checks++;
      if ({baud_locked, busy, baud_val} !== {1'b0, 1'b1, last_baud})
         $display("FAIL restart_from_lock: got L%b B%b %0d want L0 B1 %0d",
                  baud_locked, busy, baud_val, last_baud);
      else n_pass++;
      sb.push_back(model_lock(8 * 5208));
      fork
         send_frame(8'h55, 5208, 0, -1, 0, 1'b0);
         begin
            tick(20);
            n_checks++;
            if ({rx_hold, busy, baud_locked} !== 3'b110)
               $display("FAIL hold_during_measure: hold/busy/lock got %b want 110",
                        {rx_hold, busy, baud_locked});
            else n_pass++;
         end
      join
      wait_out(100, 1'b0, w);
      e = sb.pop_front();
      n_checks++;
      if (w >= 100)
         $display("FAIL lock9600: timed out waiting for lock");
      else if ({baud_locked, detect_err, baud_val, baud_val_fraction} !== e)
         $display("FAIL lock9600: got L%b E%b %0d/%0d want L%b E%b %0d/%0d",
                  baud_locked, detect_err, baud_val, baud_val_fraction,
                  e.locked, e.err, e.baud, e.frac);
      else n_pass++;
      n_checks++;
      if ({rx_hold, busy} !== 2'b00)
         $display("FAIL release_after_lock: hold/busy got %b want 00", {rx_hold, busy});
      else n_pass++;
      last_baud = e.baud; last_frac = e.frac;
   endtask

   task automatic test_tolerance_err;
      exp_t e;
      int   w;
      restart = 1'b1; tick(1); restart = 1'b0;
      sb.push_back('{locked: 1'b0, err: 1'b1, baud: last_baud, frac: last_frac});
      // d3 and d4 stretched by a quarter: third interval is 25% long
      send_frame(8'h55, 434, 4, 5, 108, 1'b0);
      wait_out(100, 1'b0, w);
      e = sb.pop_front();
      n_checks++;
      if (w >= 100)
         $display("FAIL tolerance_err: timed out waiting for error");
      else if ({baud_locked, detect_err, baud_val, baud_val_fraction} !== e)
         $display("FAIL tolerance_err: got L%b E%b %0d/%0d want L%b E%b %0d/%0d",
                  baud_locked, detect_err, baud_val, baud_val_fraction,
                  e.locked, e.err, e.baud, e.frac);
      else n_pass++;
      restart = 1'b1; tick(1); restart = 1'b0;
      n_checks++;
      if ({detect_err, busy} !== 2'b01)
         $display("FAIL restart_from_err: err/busy got %b want 01", {detect_err, busy});
      else n_pass++;
   endtask

   task automatic test_timeout;
      exp_t e;
      int   w;
      sb.push_back('{locked: 1'b0, err: 1'b1, baud: 13'd0, frac: 3'd0});
      w = 0;
      fork
         send_frame(8'h00, 434, 0, -1, 0, 1'b1);
         wait_out(6000, 1'b1, w);
      join
      n_checks++;
      if ((w < 4096) || (w > 4102))
         $display("FAIL timeout_latency: error after %0d cycles want 4096..4102", w);
      else n_pass++;
      e = sb.pop_front();
      n_checks++;
      if ({locked_to, err_to, baud_to, frac_to} !== e)
         $display("FAIL timeout_state: got L%b E%b %0d/%0d want L%b E%b %0d/%0d",
                  locked_to, err_to, baud_to, frac_to, e.locked, e.err, e.baud, e.frac);
      else n_pass++;
   endtask

   task automatic test_override;
      exp_t e;
      restart = 1'b1; tick(1); restart = 1'b0;
      sw_baud_val = 13'd100; sw_fraction = 3'd5; sw_override = 1'b1;
      sb.push_back('{locked: 1'b1, err: 1'b0, baud: 13'd100, frac: 3'd5});
      #1;
      n_checks++;
      if (baud_val !== last_baud)
         $display("FAIL override_latency: got %0d before edge want %0d", baud_val, last_baud);
      else n_pass++;
      tick(1);
      e = sb.pop_front();
      n_checks++;
      if ({baud_locked, detect_err, baud_val, baud_val_fraction} !== e)
         $display("FAIL override_values: got L%b E%b %0d/%0d want L%b E%b %0d/%0d",
                  baud_locked, detect_err, baud_val, baud_val_fraction,
                  e.locked, e.err, e.baud, e.frac);
      else n_pass++;
      sw_override = 1'b0;
      tick(3);
      rx = 1'b0;
      tick(50);
      n_checks++;
      if (busy !== 1'b1)
         $display("FAIL measure_before_override: busy got %b want 1", busy);
      else n_pass++;
      sw_override = 1'b1;
      tick(1);
      n_checks++;
      if ({busy, rx_hold} !== 2'b00)
         $display("FAIL override_to_idle: busy/hold got %b want 00", {busy, rx_hold});
      else n_pass++;
      rx = 1'b1;
      tick(5);
      sw_override = 1'b0;
      tick(5);
      n_checks++;
      if ({baud_val, baud_val_fraction} !== {13'd100, 3'd5})
         $display("FAIL override_retained: got %0d/%0d want 100/5", baud_val, baud_val_fraction);
      else n_pass++;
      last_baud = 13'd100; last_frac = 3'd5;
   endtask

   task automatic test_reset_mid_measure;
      exp_t e;
      int   w;
      fork
         send_frame(8'h55, 300, 0, -1, 0, 1'b0);
         begin
            tick(700);
            n_checks++;
            if (busy !== 1'b1)
               $display("FAIL mid_measure_busy: busy got %b want 1", busy);
            else n_pass++;
            aresetn = 1'b0;
            tick(2);
            n_checks++;
            if ({baud_val, baud_val_fraction, baud_locked, detect_err, rx_hold, busy} !== 19'd0)
               $display("FAIL reset_mid_measure: got %h want 0",
                        {baud_val, baud_val_fraction, baud_locked, detect_err, rx_hold, busy});
            else n_pass++;
            aresetn = 1'b1;
            enable  = 1'b0;
            tick(20);
            n_checks++;
            if ({busy, baud_locked, detect_err} !== 3'b000)
               $display("FAIL disabled_mid_frame: busy/lock/err got %b want 000",
                        {busy, baud_locked, detect_err});
            else n_pass++;
            // Re-arm during the d7 bit, after the frame's last falling edge
            tick(1780);
            enable = 1'b1;
         end
      join
      tick(10);
      sb.push_back(model_lock(8 * 300));
      send_frame(8'h55, 300, 0, -1, 0, 1'b0);
      wait_out(100, 1'b0, w);
      e = sb.pop_front();
      n_checks++;
      if (w >= 100)
         $display("FAIL fresh_after_reset: timed out waiting for lock");
      else if ({baud_locked, detect_err, baud_val, baud_val_fraction} !== e)
         $display("FAIL fresh_after_reset: got L%b E%b %0d/%0d want L%b E%b %0d/%0d",
                  baud_locked, detect_err, baud_val, baud_val_fraction,
                  e.locked, e.err, e.baud, e.frac);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   w;
      int   rates[2] = '{250, 517};
      for (int k = 0; k < 2; k++) begin
         restart = 1'b1; tick(1); restart = 1'b0;
         sb.push_back(model_lock(8 * rates[k]));
         send_frame(8'h55, rates[k], 0, -1, 0, 1'b0);
         wait_out(100, 1'b0, w);
         e = sb.pop_front();
         n_checks++;
         if (w >= 100)
            $display("FAIL back_to_back[%0d]: timed out waiting for lock", k);
         else if ({baud_locked, detect_err, baud_val, baud_val_fraction} !== e)
            $display("FAIL back_to_back[%0d]: got L%b E%b %0d/%0d want L%b E%b %0d/%0d", k,
                     baud_locked, detect_err, baud_val, baud_val_fraction,
                     e.locked, e.err, e.baud, e.frac);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_lock_115200();
      test_lock_9600();
      test_tolerance_err();
      test_timeout();
      test_override();
      test_reset_mid_measure();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
- Configuration controller for the UART 16x baud clock generator.
- Measures an incoming 0x55 sync character on the RX line and computes the generator's 13-bit baud value and 3-bit fractional adjust. It then holds them stable and flags lock.
- Holds the UART receiver off during measurement. A software override path passes register-programmed values straight through.

Parameters:
- CNT_W, 20, measurement counter width; equals 13 + 7 (13-bit baud value plus 7 bits for the /128 division).
- TIMEOUT_CNT, 20'hFFFFF, counter value at which an in-progress measurement aborts with an error.
- TOL_SHIFT, 3, interval tolerance is first_interval >> TOL_SHIFT (default ±1/8).

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  level; 1 arms detection, 0 forces IDLE
- restart  in  1  single-cycle pulse; drop lock and re-arm
- rx_in  in  1  raw serial RX line, asynchronous
- sw_override  in  1  1 selects the sw_* values
- sw_baud_val  in  13  software baud value
- sw_fraction  in  3  software fractional value
- baud_val  out  13  value driven to the generator's baud_val input
- baud_val_fraction  out  3  value driven to the generator's BAUD_VAL_FRACTION input
- baud_locked  out  1  measured values valid and held
- detect_err  out  1  last measurement rejected; sticky until restart or enable falls
- rx_hold  out  1  1 while measuring; UART receiver must ignore the line
- busy  out  1  FSM is in WAIT_START or MEASURE

Behaviour:
- Reset values: baud_val=0, baud_val_fraction=0, baud_locked=0, detect_err=0, rx_hold=0, busy=0, FSM in IDLE.
- rx_in passes through a 2-flop synchroniser with reset value 1. A falling edge is sync_q2=0 while the previous sample was 1.
- 0x55 is sent LSB first, so falling edges occur at the start bit, d1, d3, d5 and d7. These are 5 edges and 4 intervals of 2 bit-times each, 8 bit-times in total.
- FSM states and transitions:
  - IDLE → WAIT_START when enable=1.
  - WAIT_START: rx_hold=1. On a falling edge: clear the counter, clear edge_cnt, go to MEASURE.
  - MEASURE: counter increments every clk. On each falling edge, latch the interval and increment edge_cnt.
    - Interval 1 is stored as the reference.
    - Intervals 2–4 must lie within ref ± (ref >> TOL_SHIFT), inclusive. Otherwise go to ERROR.
    - On the 4th interval go to CALC. The total count C is the counter value at that edge.
    - If the counter reaches TIMEOUT_CNT, go to ERROR.
  - CALC (1 cycle): Q = C[19:7]. If Q==0, go to ERROR. Otherwise baud_val ← Q−1, baud_val_fraction ← C[6:4], then go to LOCKED.
  - LOCKED: baud_locked=1, rx_hold=0. Outputs are frozen. restart → WAIT_START.
  - ERROR: detect_err=1. baud_val and baud_val_fraction keep their previous values. restart → WAIT_START.
- enable=0 in any state → IDLE next cycle. baud_locked and detect_err clear; baud_val and baud_val_fraction are retained.
- restart has priority over edge detection in the same cycle. It clears baud_locked and detect_err on the next clk.
- sw_override=1: baud_val and baud_val_fraction are registered copies of sw_* with 1-cycle latency. baud_locked is forced to 1 and the FSM is held in IDLE. When override drops, the outputs keep the last sw values until a new lock.
- Output registers change only in CALC or under override, so the generator never sees a partial update.
- Async reset mid-MEASURE returns everything to the reset values; there is no partial result.

Optional Feature:
- Macro UART_AUTOBAUD_FRACTION_EN.
- Defined: baud_val_fraction = C[6:4] (truncated eighths) and baud_val = C[19:7]−1.
- Undefined: baud_val_fraction is tied to 0. baud_val = ((C+64) >> 7) − 1 (rounded to nearest); the Q==0 check uses the rounded value.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, WAIT_START, MEASURE, CALC, LOCKED, ERROR);
  - the constants BAUD_W=13, FRAC_W=3, OVERSAMPLE_LOG2=4, SYNC_BITS=8.
- One natural sub-module, uart_rx_edge_sync: 2-flop synchroniser plus falling-edge detector, reusable by the receiver.

Test Plan:
1. clk 50 MHz, 0x55 at 115200 baud (C≈3472) → LOCKED; baud_val=26, fraction=1 with the macro; baud_val=26, fraction=0 without.
2. 0x55 at 9600 baud (C≈41667) → baud_val=324, fraction=4 with the macro; baud_val=325, fraction=0 without. rx_hold=1 from the start edge until CALC.
3. 0x55 with the third interval stretched 25% → ERROR; detect_err=1, baud_locked=0, outputs unchanged. restart pulse → WAIT_START with detect_err=0.
4. 0x00 sent, then line held high, TIMEOUT_CNT=20'h01000 → ERROR after 4096 clk.
5. sw_override=1, sw_baud_val=13'd100, sw_fraction=5 → outputs 100/5 one cycle later, baud_locked=1. Override during MEASURE → FSM to IDLE.
6. aresetn asserted during MEASURE, then enable=0 and enable=1 mid-frame → all outputs at reset values; fresh measurement completes correctly on the next 0x55.
